signed_accumulator: RTL
=======================

SIGNED_ACCUMULATOR -- requirements
Module: signed_accumulator

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive identical synchronized samples required to accept a new request level (range 1..15).
REQ-002 clk_2  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 operand  input  3  two's-complement operand (-4..3), sampled in EXEC.
REQ-005 add_req  input  1  raw switch level requesting acc + operand.
REQ-006 sub_req  input  1  raw switch level requesting acc - operand.
REQ-007 clr  input  1  synchronous clear level, highest priority.
REQ-008 acc  output  3  two's-complement accumulator value; feeds the 7-segment integer display stage (bit 2 = sign).
REQ-009 overflow  output  1  result of the last executed operation left -4..3.
REQ-010 op_done  output  1  one-cycle pulse in the cycle after acc updates.
REQ-011 state  output  2  FSM state for LEDs: IDLE=00, EXEC=01, HOLD=10.

Function
REQ-012 add_req and sub_req SHALL each pass through a 2-flop synchronizer before any other use.
REQ-013 Each synchronized request SHALL have its own 4-bit stability counter; the registered debounced level changes only after DEBOUNCE_CYCLES consecutive samples differing from it, and the counter restarts on any sample equal to the current debounced level.
REQ-014 IDLE -> EXEC when exactly one debounced request is high; both high in the same cycle -> HOLD with no operation.
REQ-015 EXEC SHALL last exactly one cycle, latch the selected operation, update acc and overflow at its end, then go to HOLD.
REQ-016 HOLD -> IDLE only when both debounced requests are low; one switch press yields exactly one operation.
REQ-017 Arithmetic SHALL use 4-bit sign-extended acc and operand; the result overflows when outside -4..3.
REQ-018 Subtraction of operand -4 SHALL be computed in 4 bits (adds +4) and follow REQ-017.
REQ-019 overflow SHALL be set or cleared by every EXEC and hold its value otherwise.
REQ-020 op_done SHALL pulse high for one cycle following each EXEC and never otherwise.
REQ-021 clr high in any state: acc=0, overflow=0, op_done=0, state -> HOLD on that edge; a pending EXEC is discarded.
REQ-022 Latency: with DEBOUNCE_CYCLES=4, a clean request edge SHALL update acc on the 8th rising edge (DEBOUNCE_CYCLES+4) after the edge at which the raw input is first sampled high.
REQ-023 A raw glitch shorter than DEBOUNCE_CYCLES cycles SHALL cause no operation.
REQ-024 operand changes outside EXEC SHALL have no effect.

Reset
REQ-025 rst_n low SHALL immediately force acc=000, overflow=0, op_done=0, state=IDLE, all synchronizers, debounced levels and counters to 0.
REQ-026 Reset release with a request already held high SHALL be treated as a new press after debounce.
REQ-027 Reset asserted mid-EXEC SHALL abort the operation; acc reads 000 after release.

Configuration
REQ-028 Macro SATURATE_EN defined: an overflowing result SHALL clamp acc to 011 (+3) or 100 (-4); overflow still set.
REQ-029 SATURATE_EN undefined: acc SHALL take the low 3 bits of the 4-bit result (wrap-around); overflow still set.

Verification
REQ-030 Reset; operand=010; add_req pulse held 10 cycles -> acc=010 eight edges later, op_done one pulse, overflow=0, state returns to IDLE after release.
REQ-031 acc=010, operand=011, add -> overflow=1; acc=101 (-3) without SATURATE_EN, 011 with it.
REQ-032 acc=000, operand=100 (-4), sub -> overflow=1; acc=100 without SATURATE_EN, 011 with it.
REQ-033 add_req glitch of 3 cycles -> no op_done, acc unchanged; add_req and sub_req rising together -> HOLD, acc unchanged.
REQ-034 Hold add_req 50 cycles with operand=001 -> exactly one increment; release and press again -> second increment.
REQ-035 clr asserted in the EXEC cycle -> acc=000, overflow=0, no op_done; rst_n pulse mid-debounce -> all outputs at reset values.

Source files
------------

// File: rtl/signed_accumulator_if.sv
// Request/operand inputs and accumulator status outputs of signed_accumulator.
interface signed_accumulator_if;
  logic [2:0] operand;
  logic       add_req;
  logic       sub_req;
  logic       clr;
  logic [2:0] acc;
  logic       overflow;
  logic       op_done;
  logic [1:0] state;

  modport master (
    output operand, add_req, sub_req, clr,
    input  acc, overflow, op_done, state
  );

  modport slave (
    input  operand, add_req, sub_req, clr,
    output acc, overflow, op_done, state
  );
endinterface

// File: rtl/signed_accumulator.sv
// 3-bit signed accumulator driven by debounced add/sub switches.
// Define SATURATE_EN to clamp overflowing results instead of wrapping.
module signed_accumulator #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input logic                 clk_2,
  input logic                 rst_n,
  signed_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    HOLD = 2'b10
  } state_e;

  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_CYCLES - 1);

  // Index 0 is the add request, index 1 the sub request.
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] deb_q, deb_d;
  logic [3:0] cnt_q [2];
  logic [3:0] cnt_d [2];

  state_e     state_q, state_d;
  logic       op_sub_q, op_sub_d;
  logic [2:0] acc_q, acc_d;
  logic       overflow_q, overflow_d;
  logic       op_done_q, op_done_d;

  logic [3:0] acc_ext, opnd_ext, result;
  logic       result_ovf;

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 2'b00;
      sync2_q  <= 2'b00;
      deb_q    <= 2'b00;
      cnt_q[0] <= 4'd0;
      cnt_q[1] <= 4'd0;
    end else begin
      sync1_q  <= {bus.sub_req, bus.add_req};
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  // Any sample matching the debounced level restarts that channel's count.
  always_comb begin
    deb_d    = deb_q;
    cnt_d[0] = 4'd0;
    cnt_d[1] = 4'd0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = 4'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_sub_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_sub_q <= op_sub_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_sub_d = op_sub_q;
    if (bus.clr) begin
      state_d = HOLD;
    end else begin
      case (state_q)
        IDLE: begin
          case (deb_q)
            2'b01: begin
              state_d  = EXEC;
              op_sub_d = 1'b0;
            end
            2'b10: begin
              state_d  = EXEC;
              op_sub_d = 1'b1;
            end
            2'b11:   state_d = HOLD;
            default: state_d = IDLE;
          endcase
        end
        EXEC:    state_d = HOLD;
        HOLD:    if (deb_q == 2'b00) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // A 4-bit sum of two 3-bit signed values never overflows itself, so
  // bits 3 and 2 disagreeing means the result left -4..3.
  always_comb begin
    acc_ext    = {acc_q[2], acc_q};
    opnd_ext   = {bus.operand[2], bus.operand};
    result     = op_sub_q ? (acc_ext - opnd_ext) : (acc_ext + opnd_ext);
    result_ovf = result[3] ^ result[2];

    acc_d      = acc_q;
    overflow_d = overflow_q;
    op_done_d  = 1'b0;
    if (bus.clr) begin
      acc_d      = 3'b000;
      overflow_d = 1'b0;
    end else if (state_q == EXEC) begin
      overflow_d = result_ovf;
      op_done_d  = 1'b1;
`ifdef SATURATE_EN
      if (result_ovf) acc_d = result[3] ? 3'b100 : 3'b011;
      else            acc_d = result[2:0];
`else
      acc_d = result[2:0];
`endif
    end
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= 3'b000;
      overflow_q <= 1'b0;
      op_done_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      overflow_q <= overflow_d;
      op_done_q  <= op_done_d;
    end
  end

  assign bus.acc      = acc_q;
  assign bus.overflow = overflow_q;
  assign bus.op_done  = op_done_q;
  assign bus.state    = state_q;

endmodule
